variance_unit: RTL and testbench
================================

VARIANCE_UNIT -- requirements
Module: variance_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the bit width of samples, mean and result.
REQ-002 Parameter TOTAL_SAMPLES, default 16, SHALL set the samples per block; it SHALL be a power of two, at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 data_in  input  DATA_WIDTH  SHALL carry one unsigned sample per cycle.
REQ-006 start_data_in  input  1  SHALL be high for exactly the cycle carrying the first sample of a block.
REQ-007 mean_in  input  DATA_WIDTH  SHALL carry the unsigned block mean; it is sampled together with the first sample.
REQ-008 variance_out  output  DATA_WIDTH  SHALL carry the unsigned block variance.
REQ-009 ready  output  1  SHALL pulse high for one cycle when variance_out updates.

Function
REQ-010 States SHALL be IDLE, ACCUM and DONE.
- IDLE->ACCUM on a rising edge with start_data_in=1.
- ACCUM->DONE after sample TOTAL_SAMPLES-1 is captured.
- DONE->IDLE unconditionally after one cycle.
REQ-011 On the start edge the unit SHALL capture data_in as sample 0 and latch mean_in; later changes to mean_in SHALL have no effect on that block.
REQ-012 In ACCUM the unit SHALL capture one sample per rising edge, with no gaps, until TOTAL_SAMPLES samples are taken.
REQ-013 Per sample the unit SHALL add |data_in - mean|^2 to an accumulator of width 2*DATA_WIDTH + log2(TOTAL_SAMPLES), computed exactly and without overflow.
REQ-014 Result SHALL be accumulator >> log2(TOTAL_SAMPLES), truncated (see REQ-022), saturated to 2^DATA_WIDTH-1 if larger.
REQ-015 variance_out and ready SHALL both be registered; they update on the edge one cycle after the last sample is captured, and ready is high only during the DONE cycle.
REQ-016 variance_out SHALL hold its value until the next block completes.
REQ-017 start_data_in during ACCUM SHALL be ignored; the current block SHALL continue.
REQ-018 start_data_in during DONE SHALL be ignored; a new block can start from IDLE on the following edge.
REQ-019 The accumulator and sample counter SHALL clear on entry to ACCUM, so no value carries between blocks.

Reset
REQ-020 While rst_n=0 the unit SHALL force state=IDLE, accumulator=0, counter=0, variance_out=0, ready=0, and the latched mean=0, asynchronously.
REQ-021 Reset asserted mid-block SHALL discard the partial block; ready SHALL NOT pulse for it.

Configuration
REQ-022 Macro VARIANCE_UNIT_ROUND_EN SHALL control rounding of the result.
- Defined: add 2^(log2(TOTAL_SAMPLES)-1) to the accumulator before shifting (round half up).
- Undefined: truncate.

Structure
REQ-023 Package variance_pkg SHALL hold the state enum typedef and the accumulator-width and shift-amount helper functions/constants.
REQ-024 Sub-module sq_diff SHALL compute the combinational absolute difference and its square (2*DATA_WIDTH output); variance_unit SHALL instantiate it once.

Verification
REQ-025 Samples 1..16, mean 8, defaults -> ready pulse, variance_out=21 (22 with VARIANCE_UNIT_ROUND_EN).
REQ-026 Samples 11..26, mean 18, started two cycles after the previous ready -> variance_out=21.
REQ-027 Sixteen samples of 6, mean 6 -> variance_out=0.
REQ-028 Eight samples of 0 and eight of 255, mean 0 -> raw result 32512, so variance_out saturates to 255.
REQ-029 rst_n pulsed low after sample 7 -> ready stays 0, variance_out=0; a fresh block of 1..16 with mean 8 then gives 21.
REQ-030 start_data_in re-asserted at sample 5 -> ignored; the result equals that of the uninterrupted block.

Source files
------------

// File: rtl/variance_pkg.sv
// Shared definitions for the block-variance unit: FSM state encoding and
// helpers that size the accumulator and the final divide-by-shift.
package variance_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Right-shift that divides the accumulated sum by the block length.
    function automatic int shift_amount(input int total_samples);
        return $clog2(total_samples);
    endfunction

    // Width that holds TOTAL_SAMPLES full-scale squared differences exactly.
    function automatic int acc_width(input int data_width, input int total_samples);
        return 2 * data_width + $clog2(total_samples);
    endfunction

endpackage

// File: rtl/variance_unit_sq_diff.sv
// Combinational |a - b| followed by its exact square (2*DATA_WIDTH bits).
module sq_diff #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0]   i_a,
    input  logic [DATA_WIDTH-1:0]   i_b,
    output logic [2*DATA_WIDTH-1:0] o_sq
);

    logic [DATA_WIDTH-1:0] w_abs_diff;

    // Subtract the smaller operand from the larger so the difference never wraps.
    assign w_abs_diff = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);

    // Zero-extend before multiplying so the product keeps all 2*DATA_WIDTH bits.
    assign o_sq = {{DATA_WIDTH{1'b0}}, w_abs_diff} * {{DATA_WIDTH{1'b0}}, w_abs_diff};

endmodule

// File: rtl/variance_unit.sv
// Block variance: sums |sample - mean|^2 over TOTAL_SAMPLES consecutive samples
// and reports sum / TOTAL_SAMPLES, saturated to DATA_WIDTH bits.
// Optional feature macro: VARIANCE_UNIT_ROUND_EN (round half up instead of truncating).
module variance_unit
    import variance_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int TOTAL_SAMPLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  start_data_in,
    input  logic [DATA_WIDTH-1:0] mean_in,
    output logic [DATA_WIDTH-1:0] variance_out,
    output logic                  ready
);

    localparam int SHIFT = shift_amount(TOTAL_SAMPLES);
    localparam int ACC_W = acc_width(DATA_WIDTH, TOTAL_SAMPLES);
    localparam int CNT_W = SHIFT;
    localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(TOTAL_SAMPLES - 1);
    localparam logic [DATA_WIDTH-1:0] SAT_MAX  = {DATA_WIDTH{1'b1}};

    state_t                  r_state;
    state_t                  w_state_next;
    logic [DATA_WIDTH-1:0]   r_mean;
    logic [DATA_WIDTH-1:0]   w_mean_sel;
    logic [DATA_WIDTH-1:0]   r_variance;
    logic [DATA_WIDTH-1:0]   w_result;
    logic [2*DATA_WIDTH-1:0] w_sq;
    logic [ACC_W-1:0]        r_acc;
    logic [ACC_W-1:0]        w_acc_sum;
    logic [ACC_W-1:0]        w_acc_adj;
    logic [ACC_W-1:0]        w_acc_shifted;
    logic [CNT_W-1:0]        r_count;
    logic                    r_ready;
    logic                    w_last;

    // Sample 0 arrives with mean_in before the mean is latched, so use it directly in IDLE.
    assign w_mean_sel = (r_state == ST_IDLE) ? mean_in : r_mean;

    sq_diff #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sq_diff (
        .i_a  (data_in),
        .i_b  (w_mean_sel),
        .o_sq (w_sq)
    );

    assign w_acc_sum = r_acc + ACC_W'(w_sq);
    assign w_last    = (r_count == LAST_IDX);

`ifdef VARIANCE_UNIT_ROUND_EN
    // Half an LSB of the quotient added before the shift rounds half up.
    assign w_acc_adj = w_acc_sum + (ACC_W'(1) << (SHIFT - 1));
`else
    assign w_acc_adj = w_acc_sum;
`endif

    assign w_acc_shifted = w_acc_adj >> SHIFT;
    assign w_result      = (w_acc_shifted > ACC_W'(SAT_MAX)) ? SAT_MAX
                                                              : w_acc_shifted[DATA_WIDTH-1:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked blocks use non-blocking (<=) so every register samples pre-edge values.
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: IDLE waits for start, ACCUM runs to the last sample, DONE lasts one cycle.
    always_comb begin
        // NOTE: default first so every path assigns w_state_next and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start_data_in) w_state_next = ST_ACCUM;
            ST_ACCUM: if (w_last)        w_state_next = ST_DONE;
            ST_DONE:                     w_state_next = ST_IDLE;
            default:                     w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: latch mean, accumulate squared differences, publish the result with a ready pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_count    <= '0;
            r_mean     <= '0;
            r_variance <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_data_in) begin
                        // Loading sample 0's term (not adding) is what clears the previous block.
                        r_acc   <= ACC_W'(w_sq);
                        r_count <= CNT_W'(1);
                        r_mean  <= mean_in;
                    end
                end
                ST_ACCUM: begin
                    r_acc   <= w_acc_sum;
                    r_count <= r_count + CNT_W'(1);
                    if (w_last) begin
                        r_variance <= w_result;
                        r_ready    <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign variance_out = r_variance;
    assign ready        = r_ready;

endmodule

// File: tb/tb_variance_unit.sv
// Directed bench for variance_unit with default parameters (8-bit, 16 samples).
module tb_variance_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       start_data_in;
    logic [7:0] mean_in;
    logic [7:0] variance_out;
    logic       ready;

    int n_checks;
    int n_fail;
    int ready_pulses;
    int pulses_before;

    logic [7:0] samp [16];

`ifdef VARIANCE_UNIT_ROUND_EN
    localparam logic [7:0] EXP_RAMP = 8'd22;   // 344 / 16 = 21.5 -> 22
`else
    localparam logic [7:0] EXP_RAMP = 8'd21;   // 344 / 16 = 21.5 -> 21
`endif

    variance_unit #(
        .DATA_WIDTH    (8),
        .TOTAL_SAMPLES (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .start_data_in (start_data_in),
        .mean_in       (mean_in),
        .variance_out  (variance_out),
        .ready         (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count ready pulses on the falling edge, away from the register update.
    initial ready_pulses = 0;
    always @(negedge clk) if (ready === 1'b1) ready_pulses = ready_pulses + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive samp[0..count-1] one per cycle; mean_in is scrambled after sample 0
    // and start_data_in is re-raised at index restart_at (-1 for never).
    task automatic drive(input logic [7:0] mean, input int count, input int restart_at);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            data_in       = samp[i];
            mean_in       = (i == 0) ? mean : ~mean;
            start_data_in = (i == 0) || (i == restart_at);
        end
        @(negedge clk);
        start_data_in = 1'b0;
        data_in       = 8'd0;
    endtask

    // After a full block: ready/result in the DONE cycle, then ready low and result held.
    task automatic check_done(input string tag, input logic [7:0] exp);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_var"}, 32'(variance_out), 32'(exp));
        @(negedge clk);
        check({tag, "_ready_low"}, 32'(ready), 32'd0);
        check({tag, "_hold"}, 32'(variance_out), 32'(exp));
        check({tag, "_pulses"}, 32'(ready_pulses - pulses_before), 32'd1);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        data_in       = 8'd0;
        start_data_in = 1'b0;
        mean_in       = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_var", 32'(variance_out), 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp 1..16, mean 8: squares sum to 344.
        for (int i = 0; i < 16; i++) samp[i] = 8'(i + 1);
        pulses_before = ready_pulses;
        drive(8'd8, 16, -1);
        check_done("ramp", EXP_RAMP);

        // Ramp 11..26, mean 18: same deviations, start two cycles after ready.
        for (int i = 0; i < 16; i++) samp[i] = 8'(i + 11);
        pulses_before = ready_pulses;
        drive(8'd18, 16, -1);
        check_done("ramp_off", EXP_RAMP);

        // Constant samples equal to the mean.
        for (int i = 0; i < 16; i++) samp[i] = 8'd6;
        pulses_before = ready_pulses;
        drive(8'd6, 16, -1);
        check_done("const", 8'd0);

        // 8 x 0 and 8 x 255, mean 0: 8*65025/16 = 32512 -> saturate.
        for (int i = 0; i < 16; i++) samp[i] = (i < 8) ? 8'd0 : 8'd255;
        pulses_before = ready_pulses;
        drive(8'd0, 16, -1);
        check_done("sat", 8'd255);

        // Reset after sample 7: partial block discarded, no ready pulse.
        for (int i = 0; i < 16; i++) samp[i] = 8'(i + 1);
        pulses_before = ready_pulses;
        drive(8'd8, 8, -1);
        rst_n = 1'b0;
        #1;
        check("abort_var", 32'(variance_out), 32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_pulses", 32'(ready_pulses - pulses_before), 32'd0);
        check("abort_var_idle", 32'(variance_out), 32'd0);

        pulses_before = ready_pulses;
        drive(8'd8, 16, -1);
        check_done("fresh", EXP_RAMP);

        // start_data_in re-raised at sample 5 must not restart the block.
        pulses_before = ready_pulses;
        drive(8'd8, 16, 5);
        check_done("restart", EXP_RAMP);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always reaches its summary.
    initial begin
        #200000;
        n_fail = n_fail + 1;
        $display("FAIL timeout got=%0d exp=%0d", n_checks, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
